booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_step.sv | 37 +++
 rtl/booth_mult_seq.sv | 166 ++++++++++++++++
 tb/tb_booth_mult_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Optional unsigned mode is enabled with the BOOTH_UNSIGNED_EN macro.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // {Q[0], Q_1} recoding pairs
  localparam logic [1:0] BP_ADD = 2'b01;
  localparam logic [1:0] BP_SUB = 2'b10;

  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A,Q,Q_1}. Purely combinational.
module booth_step
  import booth_pkg::*;
#(
  parameter int XW = 8
) (
  input  logic [XW:0]   a,
  input  logic [XW-1:0] q,
  input  logic          q1,
  input  logic [XW-1:0] m,
  output logic [XW:0]   a_nx,
  output logic [XW-1:0] q_nx,
  output logic          q1_nx
);

  logic [XW:0] mx;
  logic [XW:0] sum;
  logic [1:0]  pair;

  assign mx   = {m[XW-1], m};
  assign pair = {q[0], q1};

  // add/sub selected by the recoding pair, then shift right by one
  always_comb begin
    sum = a;
    unique case (1'b1)
      (pair == BP_SUB): sum = a - mx;
      (pair == BP_ADD): sum = a + mx;
      default:          sum = a;
    endcase
    a_nx  = {sum[XW], sum[XW:1]};
    q_nx  = {sum[0], q[XW-1:1]};
    q1_nx = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with valid/ready on both sides.
// Define BOOTH_UNSIGNED_EN to add the in_signed port (unsigned mode).
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int XW = WIDTH + 1;
`else
  localparam int XW = WIDTH;
`endif
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * XW + 1;

  state_t state;
  state_t state_nx;

  logic [XW:0]   a;
  logic [XW-1:0] q;
  logic          q1;
  logic [XW-1:0] m;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [CW-1:0] n_lim;

  logic [XW:0]   a_nx;
  logic [XW-1:0] q_nx;
  logic          q1_nx;
  logic [XW-1:0] q_ld;
  logic [XW-1:0] m_ld;

  logic          shamt;
  logic [PW-1:0] full;
  logic [PW-1:0] sh;
  logic          unused_sh;

  logic load;
  logic step;
  logic fin;
  logic drop;

`ifdef BOOTH_UNSIGNED_EN
  logic sgn;

  // signed mode scans N=WIDTH bits, leaving one multiplier bit in Q[0]
  assign n_lim = sgn ? CW'(WIDTH) : CW'(WIDTH + 1);
  assign shamt = sgn;
  assign q_ld  = in_signed ? {in1[WIDTH-1], in1} : {1'b0, in1};
  assign m_ld  = in_signed ? {in2[WIDTH-1], in2} : {1'b0, in2};
`else
  assign n_lim = CW'(WIDTH);
  assign shamt = 1'b0;
  assign q_ld  = in1;
  assign m_ld  = in2;
`endif

  assign count_nx  = count + CW'(1);
  assign full      = {a_nx, q_nx};
  assign sh        = full >> shamt;
  assign unused_sh = ^sh[PW-1:2*WIDTH];

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  booth_step #(.XW(XW)) u_step (
    .a     (a),
    .q     (q),
    .q1    (q1),
    .m     (m),
    .a_nx  (a_nx),
    .q_nx  (q_nx),
    .q1_nx (q1_nx)
  );

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and datapath strobes
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load     = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (count_nx == n_lim) begin
          fin      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand/accumulator registers and the product output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a         <= '0;
      q         <= '0;
      q1        <= 1'b0;
      m         <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      sgn       <= 1'b0;
`endif
    end else begin
      if (load) begin
        a     <= '0;
        q     <= q_ld;
        q1    <= 1'b0;
        m     <= m_ld;
        count <= '0;
`ifdef BOOTH_UNSIGNED_EN
        sgn   <= in_signed;
`endif
      end else if (step) begin
        a     <= a_nx;
        q     <= q_nx;
        q1    <= q1_nx;
        count <= count_nx;
      end
      if (fin) begin
        out       <= sh[2*WIDTH-1:0];
        out_valid <= 1'b1;
      end else if (drop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=4 and WIDTH=8.
// Covers the unsigned mode too when BOOTH_UNSIGNED_EN is defined.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic       v4, r4, ordy4, ov4, bz4, s4;
  logic [3:0] a4, b4;
  logic [7:0] o4;

  logic        v8, r8, ordy8, ov8, bz8, s8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;

  int vecs = 0;
  int errs = 0;

  booth_mult_seq #(.WIDTH(4)) u4 (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (v4),
    .in_ready  (r4),
    .in1       (a4),
    .in2       (b4),
`ifdef BOOTH_UNSIGNED_EN
    .in_signed (s4),
`endif
    .out_valid (ov4),
    .out_ready (ordy4),
    .out       (o4),
    .busy      (bz4)
  );

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (v8),
    .in_ready  (r8),
    .in1       (a8),
    .in2       (b8),
`ifdef BOOTH_UNSIGNED_EN
    .in_signed (s8),
`endif
    .out_valid (ov8),
    .out_ready (ordy8),
    .out       (o8),
    .busy      (bz8)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic mul4(input logic [3:0] x, input logic [3:0] y,
                      input logic s, output logic [7:0] p,
                      output int lat);
    @(negedge clk);
    a4 = x; b4 = y; s4 = s; v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    p = o4;
    @(negedge clk);
    ordy4 = 1'b1;
    @(posedge clk);
    #1 ordy4 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] x, input logic [7:0] y,
                        input logic s);
    @(negedge clk);
    a8 = x; b8 = y; s8 = s; v8 = 1'b1;
    @(posedge clk);
    #1 v8 = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take8;
    @(negedge clk);
    ordy8 = 1'b1;
    @(posedge clk);
    #1 ordy8 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int s_lo;
    logic [7:0] p4;
    logic [7:0] e4;
    logic [3:0] x, y;

    v4 = 0; ordy4 = 0; s4 = 1; a4 = 0; b4 = 0;
    v8 = 0; ordy8 = 0; s8 = 1; a8 = 0; b8 = 0;

    #2;
    chk("rst_out4", o4, 0);
    chk("rst_ov4", ov4, 0);
    chk("rst_rdy4", r4, 1);
    chk("rst_busy4", bz4, 0);
    chk("rst_out8", o8, 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_rdy8", r8, 1);
    chk("rst_busy8", bz8, 0);
    @(negedge clk);
    n_rst = 1'b1;

    mul4(4'h3, 4'hE, 1'b1, p4, lat);
    chk("w4_3xm2", p4, 8'hFA);
    chk("w4_3xm2_lat", lat, 4);

    start8(8'h80, 8'h80, 1'b1);
    wait8(lat);
    chk("w8_80x80", o8, 16'h4000);
    chk("w8_80x80_lat", lat, 8);
    take8();

    start8(8'h80, 8'h7F, 1'b1);
    #1 chk("w8_busy_calc", bz8, 1);
    chk("w8_rdy_calc", r8, 0);
    wait8(lat);
    chk("w8_80x7f", o8, 16'hC080);
    chk("w8_80x7f_lat", lat, 8);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      @(posedge clk);
      #1;
      chk("bp_ov", ov8, 1);
      chk("bp_out", o8, 16'hC080);
      chk("bp_rdy", r8, 0);
    end
    @(negedge clk);
    v8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk);
    #1 ordy8 = 1'b0;
    chk("rel_ov", ov8, 0);
    chk("rel_rdy", r8, 1);
    chk("rel_busy", bz8, 0);
    chk("rel_out_kept", o8, 16'hC080);
    @(posedge clk);
    #1 chk("rel_no_accept", r8, 1);

    @(negedge clk);
    ordy8 = 1'b1;
    @(posedge clk);
    #1 ordy8 = 1'b0;
    chk("idle_ordy_rdy", r8, 1);
    chk("idle_ordy_ov", ov8, 0);

    start8(8'h12, 8'h34, 1'b1);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_out", o8, 0);
    chk("mid_rst_ov", ov8, 0);
    chk("mid_rst_rdy", r8, 1);
    chk("mid_rst_busy", bz8, 0);
    @(negedge clk);
    n_rst = 1'b1;

    start8(8'h05, 8'hF9, 1'b1);
    wait8(lat);
    chk("w8_5xm7", o8, 16'hFFDD);
    chk("w8_5xm7_lat", lat, 8);
    take8();

`ifdef BOOTH_UNSIGNED_EN
    start8(8'hFF, 8'hFF, 1'b0);
    wait8(lat);
    chk("u8_ffxff", o8, 16'hFE01);
    chk("u8_ffxff_lat", lat, 9);
    take8();

    start8(8'hFF, 8'hFF, 1'b1);
    wait8(lat);
    chk("s8_ffxff", o8, 16'h0001);
    chk("s8_ffxff_lat", lat, 8);
    take8();
    s_lo = 0;
`else
    s_lo = 1;
`endif

    for (int s = s_lo; s <= 1; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          x = 4'(i);
          y = 4'(j);
          if (s == 1)
            e4 = 8'($signed({{4{x[3]}}, x}) * $signed({{4{y[3]}}, y}));
          else
            e4 = 8'({4'b0, x} * {4'b0, y});
          mul4(x, y, 1'(s), p4, lat);
          chk($sformatf("w4_%0d_%0h_%0h", s, x, y), p4, e4);
          chk($sformatf("w4_lat_%0d_%0h_%0h", s, x, y), lat,
              (s == 1) ? 4 : 5);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
